// File: rtl/sdf_sphere_field_if.sv
// Point handshake, result handshake and sphere-slot configuration bundle for sdf_sphere_field.
interface sdf_sphere_field_if #(
  parameter int unsigned IDX_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [26:0]       point_x;
  logic [26:0]       point_y;
  logic [26:0]       point_z;
  logic              out_valid;
  logic              out_ready;
  logic [26:0]       distance;
  logic [IDX_W-1:0]  hit_idx;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [26:0]       cfg_cx;
  logic [26:0]       cfg_cy;
  logic [26:0]       cfg_cz;
  logic [26:0]       cfg_r;
  logic              cfg_en;

  modport master (
    output in_valid, point_x, point_y, point_z, out_ready,
    output cfg_we, cfg_addr, cfg_cx, cfg_cy, cfg_cz, cfg_r, cfg_en,
    input  in_ready, out_valid, distance, hit_idx
  );

  modport slave (
    input  in_valid, point_x, point_y, point_z, out_ready,
    input  cfg_we, cfg_addr, cfg_cx, cfg_cy, cfg_cz, cfg_r, cfg_en,
    output in_ready, out_valid, distance, hit_idx
  );
endinterface

// File: rtl/sdf_sphere_field.sv
// Min signed distance of one point over NUM_SPHERES spheres through a shared 11-cycle float
// pipeline with serial min-reduction. Define SDF_FIELD_MASK_EN to build per-slot enable bits.
module sdf_sphere_field #(
  parameter int unsigned NUM_SPHERES = 8,
  parameter int unsigned IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input logic               clk,
  input logic               reset_n,
  sdf_sphere_field_if.slave bus
);
  localparam int unsigned Lat     = 11;
  localparam int unsigned CntW    = IDX_W + 1;
  localparam int unsigned Slots   = 1 << IDX_W;
  localparam logic [26:0] PosMax  = 27'h3FBFFFF;
  localparam logic [26:0] SignBit = 27'h4000000;

  // Exponent 0 is treated as zero; results are truncated, not rounded.
  function automatic logic [26:0] fadd(input logic [26:0] a, input logic [26:0] b);
    logic [26:0] big, sml;
    logic [22:0] mb, ms, m;
    int          d, e;
    if (a[25:18] == 8'd0) return b;
    if (b[25:18] == 8'd0) return a;
    if (a[25:0] >= b[25:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    d  = int'(big[25:18]) - int'(sml[25:18]);
    mb = {2'b01, big[17:0], 3'b000};
    ms = {2'b01, sml[17:0], 3'b000};
    ms = (d > 22) ? 23'd0 : (ms >> d);
    e  = int'(big[25:18]);
    if (big[26] == sml[26]) begin
      m = mb + ms;
      if (m[22]) begin m = m >> 1; e = e + 1; end
    end else begin
      m = mb - ms;
      if (m == 23'd0) return 27'd0;
      for (int i = 0; i < 22; i++) begin
        if (!m[21]) begin m = m << 1; e = e - 1; end
      end
    end
    if (e <= 0) return 27'd0;
    if (e > 254) return {big[26], PosMax[25:0]};
    return {big[26], e[7:0], m[20:3]};
  endfunction

  function automatic logic [26:0] fsq(input logic [26:0] a);
    logic [37:0] p;
    logic [17:0] m;
    int          e;
    if (a[25:18] == 8'd0) return 27'd0;
    p = {19'd0, 1'b1, a[17:0]} * {19'd0, 1'b1, a[17:0]};
    e = 2 * int'(a[25:18]) - 127;
    if (p[37]) begin m = p[36:19]; e = e + 1; end
    else m = p[35:18];
    if (e <= 0) return 27'd0;
    if (e > 254) return PosMax;
    return {1'b0, e[7:0], m};
  endfunction

  // Odd exponents fold a factor of two into the radicand so the root stays in [1,2).
  function automatic logic [26:0] fsqrt(input logic [26:0] a);
    logic [37:0] rad;
    logic [21:0] rem, trial;
    logic [18:0] res;
    int          u, e;
    if (a[25:18] == 8'd0 || a[26]) return 27'd0;
    u   = int'(a[25:18]) - 127;
    rad = {19'd0, 1'b1, a[17:0]} << (u[0] ? 19 : 18);
    if (u[0]) u = u - 1;
    e   = u / 2 + 127;
    res = '0;
    rem = '0;
    for (int i = 18; i >= 0; i--) begin
      rem   = {rem[19:0], rad[2*i+1], rad[2*i]};
      trial = {1'b0, res, 2'b01};
      if (rem >= trial) begin rem = rem - trial; res = {res[17:0], 1'b1}; end
      else res = {res[17:0], 1'b0};
    end
    return {1'b0, e[7:0], res[17:0]};
  endfunction

  // Float less-than with -0 == +0.
  function automatic logic flt(input logic [26:0] a, input logic [26:0] b);
    logic na, nb;
    na = a[26] && (a[25:0] != 26'd0);
    nb = b[26] && (b[25:0] != 26'd0);
    if (na != nb) return na;
    if (na) return a[25:0] > b[25:0];
    return a[25:0] < b[25:0];
  endfunction

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

  state_t           r_state;
  logic             r_in_ready, r_out_valid;
  logic [26:0]      r_distance, r_acc;
  logic [IDX_W-1:0] r_hit_idx, r_acc_idx, r_cnt;
  logic [CntW-1:0]  r_ret;
  logic [26:0]      r_p [3];
  logic [26:0]      r_cx [Slots];
  logic [26:0]      r_cy [Slots];
  logic [26:0]      r_cz [Slots];
  logic [26:0]      r_cr [Slots];
  logic [26:0]      w_c [3];
  logic             w_slot_en, w_ret_en;

  assign w_c[0] = r_cx[r_cnt];
  assign w_c[1] = r_cy[r_cnt];
  assign w_c[2] = r_cz[r_cnt];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Slots); i++) begin
        r_cx[i] <= '0;
        r_cy[i] <= '0;
        r_cz[i] <= '0;
        r_cr[i] <= '0;
      end
    end else if (bus.cfg_we && (32'(bus.cfg_addr) < NUM_SPHERES)) begin
      r_cx[bus.cfg_addr] <= bus.cfg_cx;
      r_cy[bus.cfg_addr] <= bus.cfg_cy;
      r_cz[bus.cfg_addr] <= bus.cfg_cz;
      r_cr[bus.cfg_addr] <= bus.cfg_r;
    end
  end

  logic [Lat-1:0]   r_vsr;
  logic [IDX_W-1:0] r_isr [Lat];

`ifdef SDF_FIELD_MASK_EN
  logic [Slots-1:0] r_en;
  logic [Lat-1:0]   r_esr;

  always_ff @(posedge clk) begin
    if (!reset_n) r_en <= '1;
    else if (bus.cfg_we && (32'(bus.cfg_addr) < NUM_SPHERES)) r_en[bus.cfg_addr] <= bus.cfg_en;
    r_esr <= {r_esr[Lat-2:0], w_slot_en};
  end

  assign w_slot_en = r_en[r_cnt];
  assign w_ret_en  = r_esr[Lat-1];
`else
  assign w_slot_en = 1'b1;
  assign w_ret_en  = w_slot_en;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_vsr <= '0;
    else          r_vsr <= {r_vsr[Lat-2:0], r_state == StIssue};
    r_isr[0] <= r_cnt;
    for (int i = 1; i < int'(Lat); i++) r_isr[i] <= r_isr[i-1];
  end

  // Eleven register levels: diff(2), norm(7), radius subtract(2); aligned with r_vsr.
  logic [26:0] r_d0 [3];
  logic [26:0] r_d1 [3];
  logic [26:0] r_sq [3];
  logic [26:0] r_sxy, r_sz, r_sum;
  logic [26:0] r_norm [4];
  logic [26:0] r_rad [9];
  logic [26:0] r_dist [2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      r_d0[i] <= fadd(r_p[i], w_c[i] ^ SignBit);
      r_d1[i] <= r_d0[i];
      r_sq[i] <= fsq(r_d1[i]);
    end
    r_sxy   <= fadd(r_sq[0], r_sq[1]);
    r_sz    <= r_sq[2];
    r_sum   <= fadd(r_sxy, r_sz);
    r_norm[0] <= fsqrt(r_sum);
    for (int i = 1; i < 4; i++) r_norm[i] <= r_norm[i-1];
    r_rad[0] <= r_cr[r_cnt];
    for (int i = 1; i < 9; i++) r_rad[i] <= r_rad[i-1];
    r_dist[0] <= fadd(r_norm[3], r_rad[8] ^ SignBit);
    r_dist[1] <= r_dist[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_distance  <= '0;
      r_hit_idx   <= '0;
      r_cnt       <= '0;
      r_ret       <= '0;
      r_acc       <= PosMax;
      r_acc_idx   <= '0;
      for (int i = 0; i < 3; i++) r_p[i] <= '0;
    end else begin
      if (r_vsr[Lat-1]) begin
        r_ret <= r_ret + 1'b1;
        if (w_ret_en && flt(r_dist[1], r_acc)) begin
          r_acc     <= r_dist[1];
          r_acc_idx <= r_isr[Lat-1];
        end
      end
      unique case (r_state)
        StIdle: if (bus.in_valid) begin
          r_p[0]     <= bus.point_x;
          r_p[1]     <= bus.point_y;
          r_p[2]     <= bus.point_z;
          r_cnt      <= '0;
          r_ret      <= '0;
          r_acc      <= PosMax;
          r_acc_idx  <= '0;
          r_in_ready <= 1'b0;
          r_state    <= StIssue;
        end
        StIssue: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(NUM_SPHERES - 1)) r_state <= StDrain;
        end
        StDrain: if (r_ret == CntW'(NUM_SPHERES)) begin
          r_distance  <= r_acc;
          r_hit_idx   <= r_acc_idx;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.distance  = r_distance;
  assign bus.hit_idx   = r_hit_idx;
endmodule

// File: tb/tb_sdf_sphere_field.sv
// Directed bench for sdf_sphere_field: a 1-slot and a 4-slot instance, table-driven scenes plus
// backpressure, mid-drain reset and slot-enable sequences.
module tb_sdf_sphere_field;
  localparam logic [26:0] Zero   = 27'h0000000;
  localparam logic [26:0] Half   = 27'h1F80000;
  localparam logic [26:0] One    = 27'h1FC0000;
  localparam logic [26:0] OneP5  = 27'h1FE0000;
  localparam logic [26:0] Two    = 27'h2000000;
  localparam logic [26:0] Three  = 27'h2020000;
  localparam logic [26:0] Four   = 27'h2040000;
  localparam logic [26:0] NineP5 = 27'h208C000;
  localparam logic [26:0] Ten    = 27'h2090000;
  localparam logic [26:0] NOne   = 27'h5FC0000;
  localparam logic [26:0] NTwo   = 27'h6000000;
  localparam logic [26:0] PosMax = 27'h3FBFFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdf_sphere_field_if #(.IDX_W(1)) b1 ();
  sdf_sphere_field_if #(.IDX_W(2)) b4 ();

  sdf_sphere_field #(.NUM_SPHERES(1), .IDX_W(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  sdf_sphere_field #(.NUM_SPHERES(4), .IDX_W(2)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

  int n_total = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0][26:0] cx, cy, cz, r;  // element k is slot k
    logic [26:0]      px, py, pz, d;
    logic [1:0]       idx;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg4(input int a, input logic [26:0] cx, input logic [26:0] cy,
                      input logic [26:0] cz, input logic [26:0] r, input logic en);
    b4.cfg_we = 1'b1; b4.cfg_addr = 2'(a);
    b4.cfg_cx = cx; b4.cfg_cy = cy; b4.cfg_cz = cz; b4.cfg_r = r; b4.cfg_en = en;
    tick();
    b4.cfg_we = 1'b0;
  endtask

  task automatic load_vec(input int v, input logic [3:0] en);
    for (int s = 0; s < 4; s++)
      cfg4(s, vecs[v].cx[s], vecs[v].cy[s], vecs[v].cz[s], vecs[v].r[s], en[s]);
  endtask

  task automatic run4(input logic [26:0] px, input logic [26:0] py, input logic [26:0] pz,
                      output int lat, output logic [26:0] d, output logic [1:0] idx);
    b4.point_x = px; b4.point_y = py; b4.point_z = pz; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    d = b4.distance;
    idx = b4.hit_idx;
  endtask

  task automatic ack4();
    b4.out_ready = 1'b1;
    tick();
    b4.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [26:0] d;
    logic [1:0] idx;

    // Scenes, slots listed {s3, s2, s1, s0}.
    vecs[0].cx = {Ten, Two, Ten, Ten};  vecs[0].cy = '0; vecs[0].cz = '0;
    vecs[0].r  = {Half, Half, Half, Half};
    vecs[0].px = Zero; vecs[0].py = Zero; vecs[0].pz = Zero; vecs[0].d = OneP5; vecs[0].idx = 2;
    vecs[1].cx = {Ten, Ten, Ten, Two};  vecs[1].cy = '0; vecs[1].cz = '0;
    vecs[1].r  = {Half, Half, Half, Two};
    vecs[1].px = Two; vecs[1].py = Zero; vecs[1].pz = Zero; vecs[1].d = NTwo; vecs[1].idx = 0;
    vecs[2].cx = {Two, Ten, Two, Ten};  vecs[2].cy = '0; vecs[2].cz = '0;
    vecs[2].r  = {Half, Half, Half, Half};
    vecs[2].px = Zero; vecs[2].py = Zero; vecs[2].pz = Zero; vecs[2].d = OneP5; vecs[2].idx = 1;
    vecs[3].cx = {Zero, Ten, Zero, Zero}; vecs[3].cy = {Zero, Zero, Zero, Four};
    vecs[3].cz = {NTwo, Zero, Ten, Zero}; vecs[3].r = {One, Half, Half, One};
    vecs[3].px = Zero; vecs[3].py = Zero; vecs[3].pz = Zero; vecs[3].d = One; vecs[3].idx = 3;
    vecs[4].cx = {Ten, Zero, Ten, Zero}; vecs[4].cy = '0; vecs[4].cz = '0;
    vecs[4].r  = {Half, Two, Half, One};
    vecs[4].px = Zero; vecs[4].py = Zero; vecs[4].pz = Zero; vecs[4].d = NTwo; vecs[4].idx = 2;
    vecs[5].cx = {Ten, Ten, Zero, Ten}; vecs[5].cy = '0; vecs[5].cz = '0;
    vecs[5].r  = {Half, Half, One, Half};
    vecs[5].px = Three; vecs[5].py = Four; vecs[5].pz = Zero; vecs[5].d = Four; vecs[5].idx = 1;

    b1.in_valid = 0; b1.out_ready = 0; b1.cfg_we = 0; b1.cfg_addr = 0; b1.cfg_en = 1;
    b1.point_x = 0; b1.point_y = 0; b1.point_z = 0;
    b1.cfg_cx = 0; b1.cfg_cy = 0; b1.cfg_cz = 0; b1.cfg_r = 0;
    b4.in_valid = 0; b4.out_ready = 0; b4.cfg_we = 0; b4.cfg_addr = 0; b4.cfg_en = 1;
    b4.point_x = 0; b4.point_y = 0; b4.point_z = 0;
    b4.cfg_cx = 0; b4.cfg_cy = 0; b4.cfg_cz = 0; b4.cfg_r = 0;

    tick();
    tick();
    reset_n = 1'b1;
    check("rst_in_ready1", 32'(b1.in_ready), 1);
    check("rst_out_valid1", 32'(b1.out_valid), 0);
    check("rst_in_ready4", 32'(b4.in_ready), 1);
    check("rst_out_valid4", 32'(b4.out_valid), 0);
    check("rst_distance4", 32'(b4.distance), 0);
    check("rst_hit_idx4", 32'(b4.hit_idx), 0);

    // Single slot: center 0, r=1, point (2,0,0); slot index 1 is out of range and must be dropped.
    b1.cfg_we = 1; b1.cfg_addr = 0; b1.cfg_r = One;
    tick();
    b1.cfg_addr = 1; b1.cfg_cx = Two; b1.cfg_r = NTwo;
    tick();
    b1.cfg_we = 0;
    b1.point_x = Two; b1.in_valid = 1;
    tick();
    b1.in_valid = 0;
    lat = 0;
    while (b1.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("n1_distance", 32'(b1.distance), 32'(One));
    check("n1_hit_idx", 32'(b1.hit_idx), 0);
    check("n1_latency", 32'(lat), 13);
    b1.out_ready = 1;
    tick();
    b1.out_ready = 0;
    check("n1_out_valid_drop", 32'(b1.out_valid), 0);

    for (int v = 0; v < 6; v++) begin
      load_vec(v, 4'hF);
      run4(vecs[v].px, vecs[v].py, vecs[v].pz, lat, d, idx);
      check($sformatf("vec%0d_distance", v), 32'(d), 32'(vecs[v].d));
      check($sformatf("vec%0d_hit_idx", v), 32'(idx), 32'(vecs[v].idx));
      check($sformatf("vec%0d_latency", v), 32'(lat), 16);
      ack4();
      check($sformatf("vec%0d_in_ready_after", v), 32'(b4.in_ready), 1);
    end

    // Backpressure: scene 5 result held while stray in_valid pulses arrive.
    run4(Three, Four, Zero, lat, d, idx);
    for (int c = 0; c < 5; c++) begin
      b4.in_valid = c[0]; b4.point_x = Zero; b4.point_y = Zero;
      tick();
      check("hold_distance", 32'(b4.distance), 32'(Four));
      check("hold_hit_idx", 32'(b4.hit_idx), 1);
      check("hold_in_ready", 32'(b4.in_ready), 0);
      check("hold_out_valid", 32'(b4.out_valid), 1);
    end
    b4.in_valid = 0;
    ack4();
    run4(Zero, Zero, Zero, lat, d, idx);
    check("next_distance", 32'(d), 32'(NOne));
    check("next_hit_idx", 32'(idx), 1);
    check("next_latency", 32'(lat), 16);
    ack4();

    // Reset while draining scene 4 (negative results); the following point sees cleared slots.
    load_vec(4, 4'hF);
    b4.point_x = Zero; b4.point_y = Zero; b4.point_z = Zero; b4.in_valid = 1;
    tick();
    b4.in_valid = 0;
    for (int c = 0; c < 8; c++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_mid_in_ready", 32'(b4.in_ready), 1);
    check("rst_mid_out_valid", 32'(b4.out_valid), 0);
    run4(Two, Zero, Zero, lat, d, idx);
    check("post_rst_distance", 32'(d), 32'(Two));
    check("post_rst_hit_idx", 32'(idx), 0);
    check("post_rst_latency", 32'(lat), 16);
    ack4();

`ifdef SDF_FIELD_MASK_EN
    load_vec(0, 4'b1011);
    run4(Zero, Zero, Zero, lat, d, idx);
    check("mask_distance", 32'(d), 32'(NineP5));
    check("mask_hit_idx", 32'(idx), 0);
    ack4();
    load_vec(0, 4'b0000);
    run4(Zero, Zero, Zero, lat, d, idx);
    check("mask_all_distance", 32'(d), 32'(PosMax));
    check("mask_all_hit_idx", 32'(idx), 0);
    ack4();
`else
    load_vec(0, 4'b1011);
    run4(Zero, Zero, Zero, lat, d, idx);
    check("nomask_distance", 32'(d), 32'(OneP5));
    check("nomask_hit_idx", 32'(idx), 2);
    check("nomask_max_ref", 32'(d) < 32'(PosMax) ? 1 : 0, 1);
    ack4();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sdf_sphere_field.md
# sdf_sphere_field

Parametrised multi-sphere signed-distance unit for the raymarch core: takes one 27-bit-float sample point and returns the minimum SDF over NUM_SPHERES programmable spheres, plus the index of the nearest sphere. Spheres are time-multiplexed, one per cycle, through a single shared datapath: center subtract, vector norm, radius subtract. A serial min-reduction runs over that datapath's output. The block sits between the ray stepper and the march-step adder and replaces a single fixed sphere primitive with a scene of N spheres.

## Interface
- NUM_SPHERES, 8, number of sphere slots (1..64)
- IDX_W, $clog2(NUM_SPHERES) (min 1), width of sphere index
- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  sample point valid
- in_ready  out  1  block idle, point accepted on in_valid&&in_ready
- point_x, point_y, point_z  in  27 each  sample point, 27-bit float (s[26], e[25:18], m[17:0])
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- distance  out  27  min signed distance, 27-bit float
- hit_idx  out  IDX_W  index of sphere giving distance
- cfg_we  in  1  sphere slot write strobe
- cfg_addr  in  IDX_W  slot index
- cfg_cx, cfg_cy, cfg_cz, cfg_r  in  27 each  center and radius for slot
- cfg_en  in  1  slot enable bit (used only with SDF_FIELD_MASK_EN)

## Operation
- Slot file: NUM_SPHERES entries {cx,cy,cz,r,en}. Reset clears all fields to 0, en to 1. A write with cfg_addr >= NUM_SPHERES is ignored.
- Writes are accepted in any state. A slot's values are sampled on the cycle that slot is issued, so a mid-point write affects only slots not yet issued.
- Datapath per slot:
  - Stage 1: three FpAdd units (latency 2) compute point minus center, using a sign-flipped center operand.
  - Stage 2: VEC_norm (latency 7).
  - Stage 3: FpAdd (latency 2) computes norm minus r.
  - Total datapath latency is 11 cycles.
  - A valid+index shift register of depth 11 tracks each slot through the datapath.
- FSM states:
  - IDLE: in_ready=1. On accept, latch the point, clear the issue counter and the accumulator, and go to ISSUE.
  - ISSUE: issue slot idx = counter each cycle, counter++. After issuing slot NUM_SPHERES-1, go to DRAIN.
  - DRAIN: wait until the return count reaches NUM_SPHERES, then register the result and go to DONE.
  - DONE: out_valid=1; distance and hit_idx are held stable. On out_ready, go to IDLE.
- Reduction: every returned slot is compared against the accumulator.
  - Ordering is float ordering: any negative is less than any non-negative; among negatives, the larger magnitude is smaller; +0 equals -0.
  - The accumulator is replaced only on strict less-than, so ties keep the lower index.
  - The accumulator is initialised to +MAX = 27'h3FBFFFF with index 0.
- in_ready=0 in ISSUE, DRAIN and DONE. in_valid outside IDLE is ignored.
- There is no NaN/Inf handling; such inputs give an undefined result.

## Timing
- Reset values: in_ready=1, out_valid=0, distance=0, hit_idx=0, FSM=IDLE, valid shift register all 0.
- Accept at edge T: slot k is issued at T+1+k, and its result returns at T+12+k.
- out_valid rises at edge T+NUM_SPHERES+12. One point is processed at a time.
- Earliest next accept is the cycle after the out_valid&&out_ready edge, because IDLE is re-entered on that edge.
- Reset asserted mid-operation: the next edge forces the reset values and flushes the valid shift register, so no stale returns are reduced after release.

## Configuration
- SDF_FIELD_MASK_EN defined:
  - Slot en bit is stored.
  - Disabled slots are still issued, but their results are discarded and never update the accumulator.
  - If all slots are disabled, the output is distance=27'h3FBFFFF, hit_idx=0.
- SDF_FIELD_MASK_EN undefined:
  - cfg_en is ignored, no en storage is built, and all slots participate.

## Test plan
- NUM_SPHERES=1, slot0 center 0, r=1.0 (27'h1FC0000), point (2.0,0,0) (x=27'h2000000) -> distance=27'h1FC0000, hit_idx=0, out_valid exactly 13 cycles after accept.
- NUM_SPHERES=4, radius 0.5 (27'h1F80000) for all slots, slot centers x=10,10,2.0,10, point at origin -> distance=1.5 (27'h1FE0000), hit_idx=2, out_valid at accept+16.
- Point at center of slot0, r=2.0 -> distance=-2.0 (27'h6000000), hit_idx=0; verifies negative-wins ordering.
- Slots 1 and 3 identical and nearest, others far -> hit_idx=1 (tie keeps lower index).
- out_ready held low 5 cycles in DONE -> distance/hit_idx stable, in_ready=0, in_valid pulses ignored. After out_ready, the next point is accepted the following cycle.
- reset_n low for 1 cycle during DRAIN, then a new point -> result matches a fresh run, with no extra out_valid. With SDF_FIELD_MASK_EN, disabling slot2 in the second test gives hit_idx of the next-nearest slot.
